// File: rtl/usb_host_tx.sv
// Host-side USB full-speed transmitter: SYNC, LSB-first bit-stuffed NRZI data, then SE0/J EOP.
// Latency: line shows K one cycle after the first byte is accepted; every symbol lasts BIT_CYCLES cycles.
// Backpressure: in_ready only in IDLE and on the strobe ending a non-final byte; no byte there aborts with underrun.
module usb_host_tx #(
    parameter int BIT_CYCLES   = 4,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk48_host,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_dp,
    output logic       tx_dn,
    output logic       tx_oe,
    output logic       busy,
    output logic       underrun
);
    localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int ECW = $clog2(EOP_SE0_BITS + 1);
    localparam logic [BCW-1:0] BC_LAST  = BCW'(BIT_CYCLES - 1);
    localparam logic [ECW-1:0] EOP_LAST = ECW'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t         state;
    logic [BCW-1:0] bit_cnt;
    logic [ECW-1:0] eop_cnt;
    logic [2:0]     sync_idx;
    logic [2:0]     bit_idx;
    logic [2:0]     ones;
    logic [7:0]     shreg;
    logic           last_q;

    logic strobe;
    logic stuff_due;
    logic byte_done;
    logic fetch;
    logic tx_send;
    logic tx_bit;
    logic go_eop;
    logic load_new;

    assign strobe    = (state != IDLE) && (bit_cnt == BC_LAST);
    assign stuff_due = (ones == 3'd6);
    // bit_idx is the last data bit put on the line; the byte is finished once no stuff bit is owed
    assign byte_done = (bit_idx == 3'd7) && !stuff_due;
    assign fetch     = (state == DATA) && strobe && byte_done && !last_q;

    always_comb begin
        in_ready = 1'b0;
        if (!reset && (state == IDLE || fetch)) begin
            in_ready = in_valid;
        end
    end

    // Selects the next bit to place on the line at the end of the current bit time
    always_comb begin
        tx_send  = 1'b0;
        tx_bit   = 1'b0;
        go_eop   = 1'b0;
        load_new = 1'b0;
        if (strobe) begin
            case (state)
                SYNC: begin
                    tx_send = 1'b1;
                    tx_bit  = (sync_idx == 3'd7) ? shreg[0] : (sync_idx == 3'd6);
                end
                DATA: begin
                    if (stuff_due) begin
                        tx_send = 1'b1;
                        tx_bit  = 1'b0;
                    end else if (!byte_done) begin
                        tx_send = 1'b1;
                        tx_bit  = shreg[0];
                    end else if (!last_q && in_valid) begin
                        tx_send  = 1'b1;
                        tx_bit   = in_data[0];
                        load_new = 1'b1;
                    end else begin
                        go_eop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk48_host) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            eop_cnt  <= '0;
            sync_idx <= 3'd0;
            bit_idx  <= 3'd0;
            ones     <= 3'd0;
            shreg    <= 8'd0;
            last_q   <= 1'b0;
            tx_dp    <= 1'b1;
            tx_dn    <= 1'b0;
            tx_oe    <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (state != IDLE) begin
                bit_cnt <= strobe ? '0 : bit_cnt + 1'b1;
            end
            // NRZI: a 0 flips J/K, a 1 holds the line
            if (tx_send) begin
                tx_dp <= tx_bit ? tx_dp : ~tx_dp;
                tx_dn <= tx_bit ? tx_dn : ~tx_dn;
                ones  <= tx_bit ? ones + 3'd1 : 3'd0;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        last_q   <= in_last;
                        sync_idx <= 3'd0;
                        bit_idx  <= 3'd0;
                        ones     <= 3'd0;
                        bit_cnt  <= '0;
                        tx_dp    <= 1'b0;
                        tx_dn    <= 1'b1;
                        tx_oe    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (strobe) begin
                        if (sync_idx == 3'd7) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                            shreg   <= shreg >> 1;
                        end else begin
                            sync_idx <= sync_idx + 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (strobe) begin
                        if (load_new) begin
                            shreg   <= in_data >> 1;
                            last_q  <= in_last;
                            bit_idx <= 3'd0;
                        end else if (go_eop) begin
                            state    <= EOP_SE0;
                            eop_cnt  <= '0;
                            tx_dp    <= 1'b0;
                            tx_dn    <= 1'b0;
                            underrun <= !last_q;
                        end else if (!stuff_due) begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                EOP_SE0: begin
                    if (strobe) begin
                        if (eop_cnt == EOP_LAST) begin
                            state <= EOP_J;
                            tx_dp <= 1'b1;
                            tx_dn <= 1'b0;
                        end else begin
                            eop_cnt <= eop_cnt + 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    if (strobe) begin
                        state <= IDLE;
                        tx_oe <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_host_tx.sv
// Directed bench for usb_host_tx: records the driven line per cycle and compares it against hand-derived symbol strings.
module tb_usb_host_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic       tx_dp, tx_dn, tx_oe, busy, underrun;

    logic       f_reset;
    logic [7:0] f_data;
    logic       f_valid, f_last, f_ready;
    logic       f_dp, f_dn, f_oe, f_busy, f_underrun;

    usb_host_tx u_dut (
        .clk48_host(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .tx_dp(tx_dp), .tx_dn(tx_dn),
        .tx_oe(tx_oe), .busy(busy), .underrun(underrun)
    );

    usb_host_tx #(.BIT_CYCLES(2), .EOP_SE0_BITS(3)) u_fast (
        .clk48_host(clk), .reset(f_reset), .in_data(f_data), .in_valid(f_valid),
        .in_last(f_last), .in_ready(f_ready), .tx_dp(f_dp), .tx_dn(f_dn),
        .tx_oe(f_oe), .busy(f_busy), .underrun(f_underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle recording of everything the checks need
    logic [1:0] rec[$];
    logic [1:0] rec_f[$];
    int         rdy_cyc[$];
    int         oe_starts[$];
    int         ur_at[$];
    int         cyc      = 0;
    int         busy_cnt = 0;
    logic       oe_q     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && in_ready) rdy_cyc.push_back(cyc);
        if (underrun) ur_at.push_back(rec.size());
        if (busy) busy_cnt <= busy_cnt + 1;
        if (tx_oe && !oe_q) oe_starts.push_back(cyc);
        oe_q <= tx_oe;
        if (tx_oe) rec.push_back({tx_dp, tx_dn});
        if (f_oe) rec_f.push_back({f_dp, f_dn});
    end

    function automatic logic [127:0] enc(input string s);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            v = v << 2;
            if (s[i] == "J") v[1:0] = 2'b10;
            else if (s[i] == "K") v[1:0] = 2'b01;
        end
        return v;
    endfunction

    task automatic decode(input logic [1:0] q[$], input int base, input int bc,
                          output logic [127:0] v, output int werr);
        int nsym;
        v    = '0;
        werr = 0;
        nsym = (q.size() - base) / bc;
        for (int s = 0; s < nsym; s++) begin
            for (int k = 1; k < bc; k++)
                if (q[base + s*bc + k] !== q[base + s*bc]) werr++;
            v = (v << 2) | 128'(q[base + s*bc]);
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic l, output bit ok);
        bit got;
        got      = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ok = got;
    endtask

    task automatic wait_done(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!tx_oe && !busy) done = 1'b1;
        end
        chk(tag, done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           ok;
        int           base, rb, ub, bb, sb, w, lat;
        logic [127:0] v;

        reset = 1'b1; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0;
        f_reset = 1'b1; f_data = 8'd0; f_valid = 1'b0; f_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_dp", tx_dp, 1);
        chk("rst_dn", tx_dn, 0);
        chk("rst_oe", tx_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        f_reset = 1'b0;
        @(posedge clk);
        #1;

        // Single-byte ACK 0xD2
        base = rec.size(); rb = rdy_cyc.size(); ub = ur_at.size(); bb = busy_cnt; sb = oe_starts.size();
        offer(8'hD2, 1'b1, ok);
        chk("ack_accept", ok, 1);
        wait_done("ack_done");
        decode(rec, base, 4, v, w);
        chk("ack_len", rec.size() - base, 76);
        chk("ack_line", v, enc("KJKJKJKKJJKJJKKK00J"));
        chk("ack_width", w, 0);
        chk("ack_busy", busy_cnt - bb, 76);
        chk("ack_underrun", ur_at.size() - ub, 0);
        lat = (oe_starts.size() > sb && rdy_cyc.size() > rb) ? oe_starts[sb] - rdy_cyc[rb] : -1;
        chk("ack_latency", lat, 1);

        // Bit stuffing: 0xFF 0xFF
        base = rec.size();
        offer(8'hFF, 1'b0, ok);
        chk("stuff_accept0", ok, 1);
        offer(8'hFF, 1'b1, ok);
        chk("stuff_accept1", ok, 1);
        wait_done("stuff_done");
        decode(rec, base, 4, v, w);
        chk("stuff_len", rec.size() - base, 116);
        chk("stuff_line", v, enc("KJKJKJKKKKKKKJJJJJJJKKKKKK00J"));
        chk("stuff_width", w, 0);

        // Back-to-back bytes with in_valid held high
        base = rec.size(); rb = rdy_cyc.size(); ub = ur_at.size();
        offer(8'h01, 1'b0, ok);
        chk("b2b_accept0", ok, 1);
        offer(8'h02, 1'b0, ok);
        chk("b2b_accept1", ok, 1);
        offer(8'h03, 1'b1, ok);
        chk("b2b_accept2", ok, 1);
        wait_done("b2b_done");
        decode(rec, base, 4, v, w);
        chk("b2b_ready_cnt", rdy_cyc.size() - rb, 3);
        chk("b2b_gap01", (rdy_cyc.size() >= rb + 3) ? rdy_cyc[rb+1] - rdy_cyc[rb] : -1, 64);
        chk("b2b_gap12", (rdy_cyc.size() >= rb + 3) ? rdy_cyc[rb+2] - rdy_cyc[rb+1] : -1, 32);
        chk("b2b_len", rec.size() - base, 140);
        chk("b2b_line", v, enc("KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJK00J"));
        chk("b2b_underrun", ur_at.size() - ub, 0);

        // Underrun on the second fetch
        base = rec.size(); rb = rdy_cyc.size(); ub = ur_at.size();
        offer(8'h01, 1'b0, ok);
        chk("ur_accept", ok, 1);
        wait_done("ur_done");
        decode(rec, base, 4, v, w);
        chk("ur_count", ur_at.size() - ub, 1);
        chk("ur_pos", (ur_at.size() > ub) ? ur_at[ub] - base : -1, 64);
        chk("ur_len", rec.size() - base, 76);
        chk("ur_line", v, enc("KJKJKJKKKJKJKJKJ00J"));
        chk("ur_ready_cnt", rdy_cyc.size() - rb, 1);

        // Reset during byte 0, then a clean packet
        ub = ur_at.size();
        offer(8'hD2, 1'b1, ok);
        chk("rmid_accept", ok, 1);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_oe", tx_oe, 0);
        chk("rmid_dp", tx_dp, 1);
        chk("rmid_dn", tx_dn, 0);
        chk("rmid_busy", busy, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("rmid_no_underrun", ur_at.size() - ub, 0);
        base = rec.size();
        offer(8'hD2, 1'b1, ok);
        chk("rmid_accept2", ok, 1);
        wait_done("rmid_done");
        decode(rec, base, 4, v, w);
        chk("rmid_len", rec.size() - base, 76);
        chk("rmid_line", v, enc("KJKJKJKKJJKJJKKK00J"));

        // BIT_CYCLES=2, EOP_SE0_BITS=3 instance
        base = rec_f.size();
        f_data = 8'hD2; f_last = 1'b1; f_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (f_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        f_valid = 1'b0;
        chk("fast_accept", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (!f_oe && !f_busy) ok = 1'b1;
        end
        chk("fast_done", ok, 1);
        decode(rec_f, base, 2, v, w);
        chk("fast_len", rec_f.size() - base, 40);
        chk("fast_line", v, enc("KJKJKJKKJJKJJKKK000J"));
        chk("fast_width", w, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
